fb_pixel_fetch: RTL and testbench
=================================

// Module: fb_pixel_fetch
// PURPOSE
// - Framebuffer read-ahead stage between cpuram port A and the VGA pixel path.
// - Prefetches 32-bit words from RAM into a small FIFO and unpacks each word into 4 8-bit pixels.
// - Delivers one pixel per VGA request.
// - Hides RAM read latency and decouples RAM address generation from raster timing.
// PARAMETERS
// - ADDR_W     18       RAM word-address width
// - BASE_ADDR  18'h0    word address of pixel (0,0)
// - IMG_W      256      image width in pixels; must be a multiple of 4
// - IMG_H      256      image height in pixels
// - FIFO_DEPTH 8        word FIFO depth; must be a power of 2 and >= READ_LAT+2
// - READ_LAT   2        fixed RAM latency: mem_addr in cycle N -> mem_q valid in cycle N+READ_LAT
// PORTS
// - clk          in   1       pixel clock (the vgaclk domain)
// - rst          in   1       asynchronous active-low reset
// - frame_start  in   1       1-cycle pulse at start of vertical blank; restarts fetch for the next frame
// - pix_req      in   1       VGA requests the next image pixel (active-image region only)
// - pix_data     out  8       pixel value, registered
// - pix_valid    out  1       pix_data holds a requested pixel
// - underflow    out  1       sticky: a request arrived with no data; cleared by frame_start
// - mem_addr     out  ADDR_W  RAM read word address
// - mem_rd       out  1       read issued this cycle (address meaningful)
// - mem_q        in   32      RAM read data
// BEHAVIOUR
// - Reset (rst=0, async):
//   - state=IDLE; FIFO empty; in-flight pipe cleared.
//   - mem_addr=BASE_ADDR, mem_rd=0, pix_data=0, pix_valid=0, underflow=0.
// - Frame length: WORDS = IMG_W*IMG_H/4.
//   - Word k is read from BASE_ADDR+k.
//   - Byte lane 0 (bits 7:0) is the leftmost pixel; lanes 1..3 follow in order.
// - FSM:
//   - IDLE: stay until frame_start, then go to FETCH.
//   - FETCH: mem_rd=1 whenever occupancy + in_flight < FIFO_DEPTH.
//     - mem_addr increments after each issue.
//     - After WORDS issues, go to DRAIN.
//   - DRAIN: mem_rd=0; wait for frame_start, then go to FETCH.
// - On frame_start, in any state except reset:
//   - FIFO flushed, unpacker emptied, in-flight valid bits cleared (late returns are discarded).
//   - mem_addr=BASE_ADDR, word counter=0, underflow=0.
//   - Next state is FETCH; the first issue happens in the following cycle.
//   - frame_start mid-FETCH aborts the current frame in exactly this way.
// - In-flight tracking: READ_LAT-deep shift register of valid bits.
//   - Each cycle a bit set at the tail pushes mem_q into the FIFO.
//   - The credit rule guarantees push never hits a full FIFO.
//   - Push and pop in the same cycle are legal at any occupancy (occupancy unchanged).
// - Unpacker: holds the current word and lane index 0..3.
//   - pix_req with the lane available: pix_data=lane byte, pix_valid=1 in cycle N+1; lane advances.
//   - Consuming lane 3 pops the next FIFO word in the same cycle, so there is no bubble at word boundaries.
//   - An empty unpacker loads from the FIFO as soon as it is non-empty.
// - Starved request (pix_req with unpacker empty):
//   - pix_data=8'h00, pix_valid=1, underflow set.
//   - Lane does not advance, so the pixel stream is shifted until the next frame.
// - pix_req=0: pix_valid=0 next cycle; pix_data holds its last value.
// - pix_req after all WORDS*4 pixels have been delivered: treated as starved (0x00, underflow=1).
// - Counters: word counter is $clog2(WORDS+1) bits. Occupancy and credit counters are $clog2(FIFO_DEPTH+1) bits. No wrap within a frame.
// STRUCTURE
// - Package fb_pkg:
//   - PIX_PER_WORD=4
//   - typedef logic [7:0] pixel_t
//   - typedef logic [31:0] fb_word_t
//   - typedef enum {IDLE, FETCH, DRAIN} fetch_state_t
// - Sub-module fb_word_fifo: synchronous FIFO, parameter DEPTH.
//   - Ports: push, pop, din, dout (first-word-fall-through), count, flush.
//   - pop on empty is ignored; push on full is a design error (assertion).
// - Top of this block: FSM, credit/in-flight logic, address counter, unpacker.
// TESTING
// - T1 reset: drive rst=0 mid-FETCH -> all outputs at reset values immediately; no mem_rd until frame_start.
// - T2 prefetch: frame_start, pix_req=0, READ_LAT=2, DEPTH=8 -> exactly 8 reads, addresses 0..7; FIFO count=8; mem_rd stays 0.
// - T3 unpack order: mem model returns {8'hD3,8'hC2,8'hB1,8'hA0} at addr 0, then pix_req held 8 cycles -> pix_data A0,B1,C2,D3, then addr-1 bytes; pix_valid=1 each cycle; underflow=0.
// - T4 full frame: IMG_W=8, IMG_H=2 (WORDS=4) with continuous pix_req -> 16 pixels in order, then FSM in DRAIN with addresses 0..3 issued once; 17th request -> 0x00 and underflow=1.
// - T5 starvation: pix_req in the cycle after frame_start -> pix_data=0x00, underflow=1; the following frame_start clears underflow.
// - T6 abort: frame_start while 2 reads are in flight -> late mem_q data is not pushed; next reads restart at BASE_ADDR; first pixel = byte lane 0 of word 0.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and helpers for the framebuffer pixel fetch path.
package fb_pkg;

    localparam int PIX_PER_WORD = 4;

    typedef logic [7:0]  pixel_t;
    typedef logic [31:0] fb_word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    // Byte lane 0 (bits 7:0) is the leftmost pixel of a word.
    function automatic pixel_t lane_byte(input fb_word_t w, input logic [1:0] lane);
        return pixel_t'(w >> {lane, 3'b000});
    endfunction

endpackage

// File: rtl/fb_word_fifo.sv
// Synchronous word FIFO with first-word-fall-through output and a flush.
module fb_word_fifo
    import fb_pkg::*;
#(
    parameter int  DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  fb_word_t         din,
    output fb_word_t         dout,
    output logic [CNT_W-1:0] count
);

    fb_word_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pop on empty is dropped; flush overrides both push and pop.
    assign do_push = push && !flush;
    assign do_pop  = pop && (count != '0) && !flush;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // The upstream credit scheme must never push into a full FIFO.
    assert property (@(posedge clk) disable iff (!rst)
        !(do_push && !do_pop && (count == CNT_W'(DEPTH))));

endmodule

// File: rtl/fb_pixel_fetch.sv
// Framebuffer read-ahead: prefetches RAM words into a FIFO and hands out
// one 8-bit pixel per VGA request.
module fb_pixel_fetch
    import fb_pkg::*;
#(
    parameter int                ADDR_W     = 18,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int                IMG_W      = 256,
    parameter int                IMG_H      = 256,
    parameter int                FIFO_DEPTH = 8,
    parameter int                READ_LAT   = 2,
    localparam int               WORDS      = IMG_W * IMG_H / PIX_PER_WORD,
    localparam int               WCNT_W     = $clog2(WORDS + 1),
    localparam int               CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              pix_req,
    output pixel_t            pix_data,
    output logic              pix_valid,
    output logic              underflow,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  fb_word_t          mem_q,
    output fetch_state_t      dbg_state,
    output logic [CNT_W-1:0]  dbg_fifo_count
);

    fetch_state_t        state_q;
    fetch_state_t        state_d;
    logic [WCNT_W-1:0]   word_cnt;
    logic [READ_LAT-1:0] inflight_q;
    logic [CNT_W-1:0]    in_flight;
    logic [CNT_W-1:0]    fifo_count;
    logic [CNT_W:0]      credit_used;
    logic                credit_ok;
    logic                last_issue;
    logic                push;
    logic                pop;
    logic                have_pixel;
    logic [1:0]          lane;
    fb_word_t            fifo_dout;

    always_comb begin
        in_flight = '0;
        for (int i = 0; i < READ_LAT; i++) begin
            in_flight = in_flight + CNT_W'(inflight_q[i]);
        end
    end

    // A read may issue only if its data is guaranteed a FIFO slot on return.
    assign credit_used = {1'b0, fifo_count} + {1'b0, in_flight};
    assign credit_ok   = credit_used < (CNT_W + 1)'(FIFO_DEPTH);
    assign last_issue  = (word_cnt == WCNT_W'(WORDS - 1));

    always_comb begin
        state_d = state_q;
        mem_rd  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (frame_start) state_d = FETCH;
            end
            FETCH: begin
                if (frame_start) begin
                    state_d = FETCH;
                end else if (credit_ok) begin
                    mem_rd = 1'b1;
                    if (last_issue) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (frame_start) state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

    // frame_start discards everything in flight: returning data is never pushed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            mem_addr   <= BASE_ADDR;
            word_cnt   <= '0;
            inflight_q <= '0;
        end else begin
            state_q <= state_d;
            if (frame_start) begin
                mem_addr   <= BASE_ADDR;
                word_cnt   <= '0;
                inflight_q <= '0;
            end else begin
                inflight_q <= (inflight_q << 1) | READ_LAT'(mem_rd);
                if (mem_rd) begin
                    mem_addr <= mem_addr + ADDR_W'(1);
                    word_cnt <= word_cnt + WCNT_W'(1);
                end
            end
        end
    end

    assign push = inflight_q[READ_LAT-1] && !frame_start;

    fb_word_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (frame_start),
        .push  (push),
        .pop   (pop),
        .din   (mem_q),
        .dout  (fifo_dout),
        .count (fifo_count)
    );

    // Request/response: each pix_req cycle yields pix_valid=1 in the next cycle,
    // carrying either the next pixel or 0x00 when starved; no backpressure.
    // The unpacker word is the FIFO head; consuming lane 3 pops it.
    assign have_pixel = (fifo_count != '0);
    assign pop        = pix_req && have_pixel && (lane == 2'd3) && !frame_start;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lane      <= 2'd0;
            pix_data  <= '0;
            pix_valid <= 1'b0;
            underflow <= 1'b0;
        end else if (frame_start) begin
            lane      <= 2'd0;
            pix_valid <= 1'b0;
            underflow <= 1'b0;
        end else if (pix_req) begin
            pix_valid <= 1'b1;
            if (have_pixel) begin
                pix_data <= lane_byte(fifo_dout, lane);
                lane     <= lane + 2'd1;
            end else begin
                pix_data  <= '0;
                underflow <= 1'b1;
            end
        end else begin
            pix_valid <= 1'b0;
        end
    end

    assign dbg_state      = state_q;
    assign dbg_fifo_count = fifo_count;

endmodule

// File: tb/tb_fb_pixel_fetch.sv
// Directed bench for fb_pixel_fetch: full-size instance plus an 8x2 instance
// for the end-of-frame case, each fed by a fixed-latency RAM model.
module tb_fb_pixel_fetch;
    import fb_pkg::*;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // main instance (256x256)
    logic         frame_start = 1'b0;
    logic         pix_req     = 1'b0;
    pixel_t       pix_data;
    logic         pix_valid;
    logic         underflow;
    logic [17:0]  mem_addr;
    logic         mem_rd;
    fb_word_t     mem_q;
    fetch_state_t dbg_state;
    logic [3:0]   dbg_fifo_count;

    // small instance (8x2, four words per frame)
    logic         s_frame_start = 1'b0;
    logic         s_pix_req     = 1'b0;
    pixel_t       s_pix_data;
    logic         s_pix_valid;
    logic         s_underflow;
    logic [17:0]  s_mem_addr;
    logic         s_mem_rd;
    fb_word_t     s_mem_q;
    fetch_state_t s_dbg_state;
    logic [3:0]   s_dbg_fifo_count;

    fb_pixel_fetch #(
        .ADDR_W(18), .BASE_ADDR(18'h0), .IMG_W(256), .IMG_H(256),
        .FIFO_DEPTH(8), .READ_LAT(2)
    ) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .pix_req(pix_req),
        .pix_data(pix_data), .pix_valid(pix_valid), .underflow(underflow),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_q(mem_q),
        .dbg_state(dbg_state), .dbg_fifo_count(dbg_fifo_count)
    );

    fb_pixel_fetch #(
        .ADDR_W(18), .BASE_ADDR(18'h0), .IMG_W(8), .IMG_H(2),
        .FIFO_DEPTH(8), .READ_LAT(2)
    ) dut_s (
        .clk(clk), .rst(rst), .frame_start(s_frame_start), .pix_req(s_pix_req),
        .pix_data(s_pix_data), .pix_valid(s_pix_valid), .underflow(s_underflow),
        .mem_addr(s_mem_addr), .mem_rd(s_mem_rd), .mem_q(s_mem_q),
        .dbg_state(s_dbg_state), .dbg_fifo_count(s_dbg_fifo_count)
    );

    // pixel p lives in word p/4, lane p%4; word 0 = {D3,C2,B1,A0}
    function automatic logic [7:0] exp_pix(input int p);
        return 8'(32'hA0 + 32'h11 * (p % 4) + 4 * (p / 4));
    endfunction

    function automatic fb_word_t mem_word(input logic [17:0] a);
        fb_word_t w;
        w = '0;
        for (int b = 0; b < 4; b++) w[8*b +: 8] = exp_pix(4 * int'(a) + b);
        return w;
    endfunction

    // RAM models: two-cycle read latency, garbage when no read is returning
    logic        mv0 = 1'b0, mv1 = 1'b0, s_mv0 = 1'b0, s_mv1 = 1'b0;
    logic [17:0] ma0 = '0, ma1 = '0, s_ma0 = '0, s_ma1 = '0;
    logic [17:0] rd_log[$];
    logic [17:0] s_rd_log[$];

    always @(posedge clk) begin
        mv0 <= mem_rd;   ma0 <= mem_addr;   mv1 <= mv0;   ma1 <= ma0;
        s_mv0 <= s_mem_rd; s_ma0 <= s_mem_addr; s_mv1 <= s_mv0; s_ma1 <= s_ma0;
        if (mem_rd)   rd_log.push_back(mem_addr);
        if (s_mem_rd) s_rd_log.push_back(s_mem_addr);
    end

    assign mem_q   = mv1   ? mem_word(ma1)   : 32'hDEAD_BEEF;
    assign s_mem_q = s_mv1 ? mem_word(s_ma1) : 32'hDEAD_BEEF;

    // scoreboard
    logic [7:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    // driver tasks
    task automatic cycle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_frame_start();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic expect_pixels(input int first, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(exp_pix(first + i));
    endtask

    task automatic request_pixels(input int n, input string tag);
        logic [7:0] e;
        for (int i = 0; i < n; i++) begin
            pix_req = 1'b1;
            @(negedge clk);
            e = exp_q.pop_front();
            check({tag, " valid"}, 32'(pix_valid), 32'd1);
            check({tag, " data"}, 32'(pix_data), 32'(e));
        end
        pix_req = 1'b0;
    endtask

    task automatic check_addrs(input string tag, input int n);
        check({tag, " read count"}, 32'(rd_log.size()), 32'(n));
        for (int i = 0; i < rd_log.size() && i < n; i++) begin
            check({tag, " addr"}, 32'(rd_log[i]), 32'(i));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1);
    end

    initial begin
        logic [7:0] e;

        // reset state
        cycle(3);
        check("reset pix_data", 32'(pix_data), 32'd0);
        check("reset pix_valid", 32'(pix_valid), 32'd0);
        check("reset underflow", 32'(underflow), 32'd0);
        check("reset mem_rd", 32'(mem_rd), 32'd0);
        check("reset mem_addr", 32'(mem_addr), 32'd0);
        check("reset state", 32'(dbg_state), 32'(IDLE));
        rst = 1'b1;
        rd_log.delete();
        cycle(4);
        check("idle no reads", 32'(rd_log.size()), 32'd0);

        // T2 prefetch fills exactly the FIFO
        pulse_frame_start();
        cycle(20);
        check_addrs("t2", 8);
        check("t2 fifo count", 32'(dbg_fifo_count), 32'd8);
        check("t2 mem_rd idle", 32'(mem_rd), 32'd0);
        check("t2 state", 32'(dbg_state), 32'(FETCH));
        check("t2 pix_valid", 32'(pix_valid), 32'd0);

        // T3 unpack order across a word boundary
        expect_pixels(0, 8);
        request_pixels(8, "t3 pix");
        @(negedge clk);
        check("t3 valid drops", 32'(pix_valid), 32'd0);
        check("t3 data holds", 32'(pix_data), 32'hD7);
        check("t3 underflow", 32'(underflow), 32'd0);

        // T5 starvation right after frame_start
        pulse_frame_start();
        pix_req = 1'b1;
        @(negedge clk);
        pix_req = 1'b0;
        check("t5 starved valid", 32'(pix_valid), 32'd1);
        check("t5 starved data", 32'(pix_data), 32'h00);
        check("t5 underflow set", 32'(underflow), 32'd1);
        cycle(10);
        check("t5 underflow sticky", 32'(underflow), 32'd1);
        expect_pixels(0, 1);
        request_pixels(1, "t5 lane held");
        pulse_frame_start();
        check("t5 underflow cleared", 32'(underflow), 32'd0);

        // T6 abort with reads in flight
        cycle(20);
        pulse_frame_start();
        cycle(3);
        check("t6 pre-abort mem_rd", 32'(mem_rd), 32'd1);
        check("t6 pre-abort addr", 32'(mem_addr), 32'd3);
        rd_log.delete();
        pulse_frame_start();
        cycle(20);
        check_addrs("t6", 8);
        check("t6 fifo count", 32'(dbg_fifo_count), 32'd8);
        expect_pixels(0, 4);
        request_pixels(4, "t6 pix");
        check("t6 underflow", 32'(underflow), 32'd0);

        // T1 asynchronous reset mid-fetch
        pix_req = 1'b1;
        @(negedge clk);
        check("t1 pre valid", 32'(pix_valid), 32'd1);
        check("t1 pre data", 32'(pix_data), 32'(exp_pix(4)));
        #2 rst = 1'b0;
        #1;
        check("t1 pix_data", 32'(pix_data), 32'd0);
        check("t1 pix_valid", 32'(pix_valid), 32'd0);
        check("t1 mem_rd", 32'(mem_rd), 32'd0);
        check("t1 mem_addr", 32'(mem_addr), 32'd0);
        check("t1 state", 32'(dbg_state), 32'(IDLE));
        check("t1 fifo count", 32'(dbg_fifo_count), 32'd0);
        pix_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        rd_log.delete();
        cycle(6);
        check("t1 no reads after reset", 32'(rd_log.size()), 32'd0);
        check("t1 state idle", 32'(dbg_state), 32'(IDLE));
        pulse_frame_start();
        cycle(3);
        check_addrs("t1 restart", 3);

        // T4 full 8x2 frame on the small instance
        s_rd_log.delete();
        s_frame_start = 1'b1;
        @(negedge clk);
        s_frame_start = 1'b0;
        cycle(12);
        check("t4 state drain", 32'(s_dbg_state), 32'(DRAIN));
        check("t4 fifo count", 32'(s_dbg_fifo_count), 32'd4);
        check("t4 read count", 32'(s_rd_log.size()), 32'd4);
        for (int i = 0; i < s_rd_log.size() && i < 4; i++) begin
            check("t4 addr", 32'(s_rd_log[i]), 32'(i));
        end
        expect_pixels(0, 16);
        for (int i = 0; i < 16; i++) begin
            s_pix_req = 1'b1;
            @(negedge clk);
            e = exp_q.pop_front();
            check("t4 pix valid", 32'(s_pix_valid), 32'd1);
            check("t4 pix data", 32'(s_pix_data), 32'(e));
        end
        check("t4 no underflow", 32'(s_underflow), 32'd0);
        @(negedge clk);
        s_pix_req = 1'b0;
        check("t4 17th valid", 32'(s_pix_valid), 32'd1);
        check("t4 17th data", 32'(s_pix_data), 32'h00);
        check("t4 17th underflow", 32'(s_underflow), 32'd1);
        check("t4 reads once", 32'(s_rd_log.size()), 32'd4);

        // final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
